// File: rtl/alu_func_pkg.sv
// Function codes shared by ALU control, ALU, shifter and the HI/LO multiplier,
// plus the multiplier's control state encoding.
package alu_func_pkg;

    localparam logic [5:0] AND       = 6'b100100;
    localparam logic [5:0] OR        = 6'b100101;
    localparam logic [5:0] ADD       = 6'b100000;
    localparam logic [5:0] SUB       = 6'b100010;
    localparam logic [5:0] SLT       = 6'b101010;
    localparam logic [5:0] SRL       = 6'b000010;
    localparam logic [5:0] MUL       = 6'b011001;
    localparam logic [5:0] MFHI      = 6'b010000;
    localparam logic [5:0] MFLO      = 6'b010010;
    localparam logic [5:0] OPEN_HILO = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_shift_add_step.sv
// One shift-add multiply iteration on the {p_hi, p_lo} product register.
module mul_shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] p_hi,
    input  logic [WIDTH-1:0] p_lo,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, p_hi};
        if (p_lo[0]) begin
            sum = {1'b0, p_hi} + {1'b0, mcand};
        end
    end

    // Carry is kept: the 65-bit {sum, p_lo} shifts right by one.
    assign next_hi = sum[WIDTH:1];
    assign next_lo = {sum[0], p_lo[WIDTH-1:1]};

endmodule

// File: rtl/mul_hilo_unit.sv
// Sequential unsigned multiplier driven by the ALU control SignaltoMUL stream,
// with a HI/LO register pair committed on OPEN_HILO and read via MFHI/MFLO.
//
// state | meaning
// IDLE  | waiting for MUL; first MUL edge latches operands and runs iteration 0
// RUN   | iterating while Signal stays MUL; any other code aborts
// DONE  | product complete, waiting for OPEN_HILO to commit into HI/LO
module mul_hilo_unit
    import alu_func_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             ready
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mul_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH-1:0] step_hi_in;
    logic [WIDTH-1:0] step_lo_in;
    logic [WIDTH-1:0] step_mcand;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // Iteration 0 works straight from the ports so no extra load cycle is needed.
    always_comb begin
        step_hi_in = p_hi;
        step_lo_in = p_lo;
        step_mcand = mcand;
        if (state == IDLE) begin
            step_hi_in = '0;
            step_lo_in = dataB;
            step_mcand = dataA;
        end
    end

    mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
        .p_hi    (step_hi_in),
        .p_lo    (step_lo_in),
        .mcand   (step_mcand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            mcand <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Signal == MUL) begin
                        mcand <= dataA;
                        p_hi  <= step_hi;
                        p_lo  <= step_lo;
                        count <= CW'(1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (Signal == MUL) begin
                        p_hi  <= step_hi;
                        p_lo  <= step_lo;
                        count <= count + CW'(1);
                        if (count == LAST) begin
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (Signal == OPEN_HILO) begin
                        hi    <= p_hi;
                        lo    <= p_lo;
                        state <= IDLE;
                    end else if (Signal != MUL) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == RUN);
    assign ready = (state == DONE);

    always_comb begin
        dataOut = '0;
        if (Signal == MFHI) begin
            dataOut = hi;
        end else if (Signal == MFLO) begin
            dataOut = lo;
        end
    end

endmodule
